// File: rtl/axi_common_pkg.sv
// rtl/axi_common_pkg.sv - shared AXI response encodings
package axi_common_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_channel.sv
// rtl/axi_lite_channel.sv - AXI-lite channel bundle with master/slave views
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input logic clk,
  input logic rstn
);

  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    input  clk, rstn,
    output aw_addr, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input  b_resp, b_valid, output b_ready,
    output ar_addr, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid, output r_ready
  );

  modport slave (
    input  clk, rstn,
    input  aw_addr, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input  ar_addr, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );

endinterface

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock circular FIFO with occupancy count
module fifo_sync #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/axi_lite_bram_ctrl_pl.sv
// rtl/axi_lite_bram_ctrl_pl.sv - AXI-lite slave onto one BRAM port, pipelined reads
// Writes and reads share the port under round-robin; read responses queue in a FIFO.
module axi_lite_bram_ctrl_pl
  import axi_common_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_ADDR_WIDTH = 12,
  parameter int READ_LATENCY    = 1,
  parameter int FIFO_DEPTH      = READ_LATENCY + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  axi_lite_channel.slave             master,
  output logic                       bram_en,
  output logic [DATA_WIDTH/8-1:0]    bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0]      bram_wrdata,
  input  logic [DATA_WIDTH-1:0]      bram_rddata
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int HI_LSB   = BRAM_ADDR_WIDTH + ADDR_LSB;
  localparam int FCNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam int ENT_W    = DATA_WIDTH + 2;

  logic                    b_valid_q, b_valid_d;
  logic [1:0]              b_resp_q, b_resp_d;
  logic                    prio_w_q, prio_w_d;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [READ_LATENCY-1:0] tag_err_q, tag_err_d;

  logic              aw_oor, ar_oor;
  logic              b_free, wr_elig, rd_elig, wr_grant, rd_grant;
  logic [CNT_W-1:0]  inflight, occ;
  logic              r_valid, fifo_push, fifo_pop, fifo_empty;
  logic [ENT_W-1:0]  fifo_wdata, fifo_rdata;
  logic [FCNT_W-1:0] fifo_count;

  always_comb begin
    aw_oor   = (master.aw_addr >> HI_LSB) != '0;
    ar_oor   = (master.ar_addr >> HI_LSB) != '0;
    inflight = CNT_W'($countones(tag_vld_q));
    r_valid  = !rst && !fifo_empty;
    fifo_pop = r_valid && master.r_ready;
    // A beat leaving this cycle frees its slot for a read accepted this cycle.
    occ      = inflight + CNT_W'(fifo_count) - CNT_W'(fifo_pop);
    b_free   = !b_valid_q || master.b_ready;
    wr_elig  = !rst && master.aw_valid && master.w_valid && b_free;
    rd_elig  = !rst && master.ar_valid && (occ < CNT_W'(FIFO_DEPTH));
    wr_grant = wr_elig && (!rd_elig || prio_w_q);
    rd_grant = rd_elig && !wr_grant;

    prio_w_d = prio_w_q;
    if (wr_elig && rd_elig) begin
      prio_w_d = !wr_grant;
    end

    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    if (b_valid_q && master.b_ready) begin
      b_valid_d = 1'b0;
    end
    if (wr_grant) begin
      b_valid_d = 1'b1;
      b_resp_d  = aw_oor ? RESP_DECERR : RESP_OKAY;
    end

    tag_vld_d  = READ_LATENCY'({tag_vld_q, rd_grant});
    tag_err_d  = READ_LATENCY'({tag_err_q, ar_oor});
    fifo_push  = tag_vld_q[READ_LATENCY-1];
    fifo_wdata = tag_err_q[READ_LATENCY-1] ? {{DATA_WIDTH{1'b0}}, RESP_DECERR}
                                           : {bram_rddata, RESP_OKAY};

    bram_en     = (wr_grant && !aw_oor) || (rd_grant && !ar_oor);
    bram_we     = (wr_grant && !aw_oor) ? master.w_strb : '0;
    bram_addr   = wr_grant ? master.aw_addr[ADDR_LSB +: BRAM_ADDR_WIDTH]
                           : master.ar_addr[ADDR_LSB +: BRAM_ADDR_WIDTH];
    bram_wrdata = master.w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      prio_w_q  <= 1'b1;
      tag_vld_q <= '0;
      tag_err_q <= '0;
    end else begin
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      prio_w_q  <= prio_w_d;
      tag_vld_q <= tag_vld_d;
      tag_err_q <= tag_err_d;
    end
  end

  fifo_sync #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign master.aw_ready = wr_grant;
  assign master.w_ready  = wr_grant;
  assign master.ar_ready = rd_grant;
  assign master.b_valid  = b_valid_q && !rst;
  assign master.b_resp   = b_resp_q;
  assign master.r_valid  = r_valid;
  assign master.r_data   = fifo_rdata[ENT_W-1:2];
  assign master.r_resp   = fifo_rdata[1:0];

endmodule

// File: tb/tb_axi_lite_bram_ctrl_pl.sv
// tb/tb_axi_lite_bram_ctrl_pl.sv - scoreboard bench for the AXI-lite BRAM bridge
module tb_axi_lite_bram_ctrl_pl;

  localparam int DW  = 64;
  localparam int BAW = 12;
  localparam int RL  = 2;
  localparam int FD  = RL + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          bram_en;
  logic [7:0]    bram_we;
  logic [BAW-1:0] bram_addr;
  logic [DW-1:0] bram_wrdata;
  logic [DW-1:0] bram_rddata;

  always #5 clk = ~clk;

  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) bus (.clk(clk), .rstn(!rst));

  axi_lite_bram_ctrl_pl #(
    .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(BAW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .master(bus),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  logic [DW-1:0] bram_mem [0:(1<<BAW)-1];
  logic [DW-1:0] rd_p0 = '0, rd_p1 = '0;
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 8; b++)
        if (bram_we[b]) bram_mem[bram_addr][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
      rd_p0 <= bram_mem[bram_addr];
    end
    rd_p1 <= rd_p0;
  end
  assign bram_rddata = rd_p1;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    int            cyc;
    bit            lat;
  } rexp_t;

  rexp_t         rq[$];
  logic [1:0]    bq[$];
  byte           glog[$];
  logic [DW-1:0] shadow [int];
  int total = 0, bad = 0;
  int cyc = 0, ar_hs_cnt = 0, r_beats = 0;
  bit lat_en = 0, log_en = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] shadow_rd(input int w);
    return shadow.exists(w) ? shadow[w] : '0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rexp_t e;
    logic oor;
    logic [DW-1:0] tmp;
    if (!rst) begin
      if (bus.aw_valid && bus.aw_ready) begin
        oor = (bus.aw_addr >> (BAW + 3)) != 0;
        check("w_ready_pair", bus.w_ready, 1);
        check("wr_bram_en", bram_en, !oor);
        check("wr_bram_we", bram_we, oor ? 8'h00 : bus.w_strb);
        if (!oor) begin
          check("wr_bram_addr", bram_addr, bus.aw_addr[BAW+2:3]);
          check("wr_bram_data", bram_wrdata, bus.w_data);
          tmp = shadow_rd(int'(bus.aw_addr[BAW+2:3]));
          for (int b = 0; b < 8; b++)
            if (bus.w_strb[b]) tmp[b*8 +: 8] = bus.w_data[b*8 +: 8];
          shadow[int'(bus.aw_addr[BAW+2:3])] = tmp;
        end
        bq.push_back(oor ? 2'b11 : 2'b00);
      end else begin
        check("we_not_write", bram_we, 0);
      end
      if (bus.ar_valid && bus.ar_ready) begin
        oor = (bus.ar_addr >> (BAW + 3)) != 0;
        ar_hs_cnt++;
        check("rd_bram_en", bram_en, !oor);
        if (!oor) check("rd_bram_addr", bram_addr, bus.ar_addr[BAW+2:3]);
        e.data = oor ? '0 : shadow_rd(int'(bus.ar_addr[BAW+2:3]));
        e.resp = oor ? 2'b11 : 2'b00;
        e.cyc  = cyc;
        e.lat  = lat_en;
        rq.push_back(e);
      end
      if (bus.r_valid && bus.r_ready) begin
        r_beats++;
        if (rq.size() == 0) begin
          check("r_spurious", bus.r_valid, 0);
        end else begin
          e = rq.pop_front();
          check("r_data", bus.r_data, e.data);
          check("r_resp", bus.r_resp, e.resp);
          if (e.lat) check("r_latency", cyc - e.cyc, RL + 1);
        end
      end
      if (bus.b_valid && bus.b_ready) begin
        if (bq.size() == 0) check("b_spurious", bus.b_valid, 0);
        else check("b_resp", bus.b_resp, bq.pop_front());
      end
      if (log_en) glog.push_back(bus.aw_ready ? "W" : (bus.ar_ready ? "R" : "-"));
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [DW-1:0] d, input logic [7:0] s);
    int n = 0;
    bus.aw_addr = a; bus.w_data = d; bus.w_strb = s;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.aw_ready && n < 50);
    if (!bus.aw_ready) check("aw_timeout", bus.aw_ready, 1);
    @(posedge clk); #1;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] base, input int n, input int stride);
    int sent = 0, guard = 0;
    bus.ar_addr = base; bus.ar_valid = 1'b1;
    while (sent < n && guard < 200) begin
      @(negedge clk); guard++;
      if (bus.ar_ready) sent++;
      @(posedge clk); #1;
      bus.ar_addr = base + 32'(sent * stride);
    end
    bus.ar_valid = 1'b0;
    check("ar_burst_sent", sent, n);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
    check("drain_r", rq.size(), 0);
    check("drain_b", bq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    string exp_g;
    int base;
    for (int i = 0; i < (1 << BAW); i++) bram_mem[i] = '0;
    bus.aw_addr = 32'h8; bus.w_data = '1; bus.w_strb = 8'hFF;
    bus.ar_addr = 32'h8; bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_aw_ready", bus.aw_ready, 0);
    check("rst_w_ready", bus.w_ready, 0);
    check("rst_ar_ready", bus.ar_ready, 0);
    check("rst_b_valid", bus.b_valid, 0);
    check("rst_r_valid", bus.r_valid, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_we", bram_we, 0);
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Arbitration: both requesters valid for four cycles
    bus.aw_addr = 32'h300; bus.w_data = 64'hCAFE_F00D_0000_0001; bus.w_strb = 8'hFF;
    bus.ar_addr = 32'h18;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1; log_en = 1'b1;
    repeat (4) @(posedge clk); #1;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0; log_en = 1'b0;
    exp_g = "WRWR";
    check("grant_count", glog.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("grant_%0d", i), glog[i], exp_g.getc(i));
    drain();

    axi_write(32'h10, 64'h1122334455667788, 8'hFF);
    drain();
    lat_en = 1'b1;
    read_burst(32'h10, 1, 0);
    drain();
    lat_en = 1'b0;

    axi_write(32'h20, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    axi_write(32'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
    read_burst(32'h20, 1, 0);
    read_burst(32'h10, 1, 0);
    read_burst(32'h1 << (BAW + 3), 1, 0);
    axi_write(32'h1 << (BAW + 3), 64'h5, 8'hFF);
    drain();

    for (int i = 0; i < 8; i++) axi_write(32'h200 + 32'(i * 8), {$urandom, $urandom}, 8'hFF);
    drain();
    bus.r_ready = 1'b0;
    base = ar_hs_cnt;
    fork
      read_burst(32'h200, 8, 8);
      begin
        repeat (10) @(posedge clk); #1;
        check("ar_outstanding", ar_hs_cnt - base, FD);
        check("ar_ready_full", bus.ar_ready, 0);
        bus.r_ready = 1'b1;
      end
    join
    drain();

    read_burst(32'h200, 2, 8);
    rst = 1'b1;
    rq.delete(); bq.delete();
    base = r_beats;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("r_after_rst", r_beats - base, 0);
    lat_en = 1'b1;
    read_burst(32'h208, 1, 0);
    drain();
    lat_en = 1'b0;
    check("post_rst_reads", r_beats - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
